// File: rtl/tb_irq_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_irq_stim_gen
//
// Interrupt-stimulus generator for the core simulation bench. One instance
// drives one IRQ line (ext, sft or tmr). Once the commit stream reaches
// START_PC the generator loops: wait a pseudo-random 1..2^WAIT_LOG2 cycles,
// raise irq_o, hold it until the handler's pre-mret PC (HANDLER_PC) commits,
// drop it and draw a new delay. A 16-bit Galois LFSR supplies the delays and
// advances only when a delay is drawn, so a given seed always yields the
// same delay sequence regardless of how long each IRQ was held.
//
// Ports:
//   clk            in   core clock
//   rst_n          in   asynchronous active-low reset
//   enable         in   generator enable; low returns to IDLE (except DONE)
//   cmt_valid      in   ALU commit valid
//   cmt_pc         in   ALU commit PC [PC_SIZE-1:0]
//   stop_i         in   request to finish; moves WAIT/ASSERT-ack to DONE
//   irq_o          out  interrupt request (registered)
//   irq_cnt_o      out  number of acknowledged IRQs, saturating [31:0]
//   done_o         out  high while in DONE (terminal until reset)
//   timeout_err_o  out  sticky: an IRQ stayed unacknowledged too long
// ---------------------------------------------------------------------------
module tb_irq_stim_gen #(
  parameter int                 PC_SIZE     = 32,
  parameter logic [PC_SIZE-1:0] START_PC    = 32'h8000015C,
  parameter logic [PC_SIZE-1:0] HANDLER_PC  = 32'h800000A6,
  parameter int                 WAIT_LOG2   = 4,
  parameter logic [15:0]        LFSR_SEED   = 16'h0001,
  parameter int                 TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cmt_valid,
  input  logic [PC_SIZE-1:0] cmt_pc,
  input  logic               stop_i,
  output logic               irq_o,
  output logic [31:0]        irq_cnt_o,
  output logic               done_o,
  output logic               timeout_err_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ASSERT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Wait counter must hold values up to 2^WAIT_LOG2 inclusive.
  localparam int WCW = WAIT_LOG2 + 1;
  // Hold counter must reach TIMEOUT_CYC-1; one spare bit keeps it non-zero width.
  localparam int HCW = $clog2(TIMEOUT_CYC) + 1;

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(TIMEOUT_CYC - 1);

  logic [1:0]     state_q, state_d;
  logic           irq_q, irq_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           done_q, done_d;
  logic           terr_q, terr_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [15:0]    lfsr_q, lfsr_d;

  logic           start_hit;
  logic           ack_hit;
  logic [WCW-1:0] draw_delay;
  logic [15:0]    lfsr_step;
  logic [31:0]    cnt_inc;

  assign start_hit = cmt_valid & (cmt_pc == START_PC);
  assign ack_hit   = cmt_valid & (cmt_pc == HANDLER_PC);

  // Delay for the next WAIT and the LFSR value after that draw.
  assign draw_delay = {1'b0, lfsr_q[WAIT_LOG2-1:0]} + WCW'(1);
  assign lfsr_step  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign cnt_inc    = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    terr_d  = terr_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    lfsr_d  = lfsr_q;

    if (state_q != ST_DONE && !enable) begin
      state_d = ST_IDLE;
      irq_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          irq_d = 1'b0;
          if (start_hit) begin
            wait_d  = draw_delay;
            lfsr_d  = lfsr_step;
            state_d = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (stop_i) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (wait_q <= WCW'(1)) begin
            // Treat a stray zero like one so the counter can never wrap.
            state_d = ST_ASSERT;
            irq_d   = 1'b1;
            hold_d  = '0;
            wait_d  = '0;
          end else begin
            wait_d = wait_q - WCW'(1);
          end
        end

        ST_ASSERT: begin
          hold_d = hold_q + HCW'(1);
          // Acknowledge wins over a timeout landing in the same cycle.
          if (ack_hit) begin
            irq_d = 1'b0;
            cnt_d = cnt_inc;
            if (stop_i) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              wait_d  = draw_delay;
              lfsr_d  = lfsr_step;
              state_d = ST_WAIT;
            end
          end else if (hold_q == HOLD_LAST) begin
            irq_d   = 1'b0;
            terr_d  = 1'b1;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end

        default: begin
          irq_d  = 1'b0;
          done_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
      wait_q  <= '0;
      hold_q  <= '0;
      lfsr_q  <= LFSR_INIT;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign irq_o         = irq_q;
  assign irq_cnt_o     = cnt_q;
  assign done_o        = done_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_tb_irq_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_tb_irq_stim_gen
//
// Directed bench for tb_irq_stim_gen (seed 1, WAIT_LOG2=4, TIMEOUT_CYC=16).
// Delay sequence from seed 1: lfsr 0001 -> D=2, B400 -> D=1, 5A00 -> D=1, ...
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tb_irq_stim_gen;

  localparam logic [31:0] START_PC   = 32'h8000015C;
  localparam logic [31:0] HANDLER_PC = 32'h800000A6;
  localparam logic [31:0] OTHER_PC   = 32'h80000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        cmt_valid;
  logic [31:0] cmt_pc;
  logic        stop_i;
  logic        irq_o;
  logic [31:0] irq_cnt_o;
  logic        done_o;
  logic        timeout_err_o;

  int n_checks = 0;
  int n_errors = 0;

  tb_irq_stim_gen #(
    .PC_SIZE     (32),
    .START_PC    (START_PC),
    .HANDLER_PC  (HANDLER_PC),
    .WAIT_LOG2   (4),
    .LFSR_SEED   (16'h0001),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .cmt_valid     (cmt_valid),
    .cmt_pc        (cmt_pc),
    .stop_i        (stop_i),
    .irq_o         (irq_o),
    .irq_cnt_o     (irq_cnt_o),
    .done_o        (done_o),
    .timeout_err_o (timeout_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    cmt_valid = v;
    cmt_pc    = pc;
  endtask

  // Reset pulse placed between edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    stop_i    = 1'b0;
    drive(1'b0, OTHER_PC);
    step();
    step();
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_cnt", irq_cnt_o, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err_o}, 32'd0);
    rst_n = 1'b1;

    // ---- 1: first delay is 2, ack, next delay 1 -------------------------
    enable = 1'b1;
    drive(1'b1, START_PC);
    step();                                   // E0: draw D=2
    drive(1'b0, OTHER_PC);
    chk("t1_wait_e0", {31'd0, irq_o}, 32'd0);
    step();
    chk("t1_wait_e1", {31'd0, irq_o}, 32'd0);
    step();
    chk("t1_assert_e2", {31'd0, irq_o}, 32'd1);

    // ---- 6: ack without valid, start while asserted -------------------
    drive(1'b0, HANDLER_PC);
    step();
    chk("t6_novalid_irq", {31'd0, irq_o}, 32'd1);
    chk("t6_novalid_cnt", irq_cnt_o, 32'd0);
    drive(1'b1, START_PC);
    step();
    chk("t6_start_irq", {31'd0, irq_o}, 32'd1);
    chk("t6_start_cnt", irq_cnt_o, 32'd0);

    drive(1'b1, HANDLER_PC);
    step();                                   // E1: ack, draw D=1
    drive(1'b0, OTHER_PC);
    chk("t1_ack_irq", {31'd0, irq_o}, 32'd0);
    chk("t1_ack_cnt", irq_cnt_o, 32'd1);
    step();
    chk("t1_reassert", {31'd0, irq_o}, 32'd1);

    // ---- 4: enable dropped mid-assert, resume with next draw ----------
    enable = 1'b0;
    step();
    chk("t4_disable_irq", {31'd0, irq_o}, 32'd0);
    step();
    chk("t4_idle_irq", {31'd0, irq_o}, 32'd0);
    chk("t4_cnt_kept", irq_cnt_o, 32'd1);
    enable = 1'b1;
    drive(1'b1, START_PC);
    step();                                   // draw from lfsr 5A00: D=1
    drive(1'b0, OTHER_PC);
    chk("t4_restart_wait", {31'd0, irq_o}, 32'd0);
    step();
    chk("t4_resume_d1", {31'd0, irq_o}, 32'd1);

    // ---- 5: asynchronous reset mid-assert -----------------------------
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_async_irq", {31'd0, irq_o}, 32'd0);
    chk("t5_async_cnt", irq_cnt_o, 32'd0);
    #1;
    rst_n = 1'b1;
    drive(1'b1, START_PC);
    step();                                   // seed restored: D=2
    drive(1'b0, OTHER_PC);
    chk("t5_wait_e0", {31'd0, irq_o}, 32'd0);
    step();
    chk("t5_wait_e1", {31'd0, irq_o}, 32'd0);
    step();
    chk("t5_assert_e2", {31'd0, irq_o}, 32'd1);

    // ---- 3b: ack together with stop -----------------------------------
    drive(1'b1, HANDLER_PC);
    stop_i = 1'b1;
    step();
    drive(1'b0, OTHER_PC);
    stop_i = 1'b0;
    chk("t3_ackstop_irq", {31'd0, irq_o}, 32'd0);
    chk("t3_ackstop_cnt", irq_cnt_o, 32'd1);
    chk("t3_ackstop_done", {31'd0, done_o}, 32'd1);
    drive(1'b1, START_PC);
    step();
    step();
    step();
    drive(1'b0, OTHER_PC);
    chk("t3_done_sticky", {31'd0, done_o}, 32'd1);
    chk("t3_done_noirq", {31'd0, irq_o}, 32'd0);

    // ---- 3a: stop during WAIT -----------------------------------------
    pulse_reset();
    drive(1'b1, START_PC);
    step();                                   // D=2, counter at 2
    drive(1'b0, OTHER_PC);
    stop_i = 1'b1;
    step();
    stop_i = 1'b0;
    chk("t3_wstop_done", {31'd0, done_o}, 32'd1);
    chk("t3_wstop_irq", {31'd0, irq_o}, 32'd0);
    step();
    step();
    chk("t3_wstop_noirq", {31'd0, irq_o}, 32'd0);
    chk("t3_wstop_cnt", irq_cnt_o, 32'd0);

    // ---- 2: timeout after exactly 16 asserted cycles ------------------
    pulse_reset();
    drive(1'b1, START_PC);
    step();
    drive(1'b0, OTHER_PC);
    step();
    step();
    chk("t2_assert", {31'd0, irq_o}, 32'd1);
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("t2_hold_%0d", i), {31'd0, irq_o}, 32'd1);
    end
    step();
    chk("t2_timeout_irq", {31'd0, irq_o}, 32'd0);
    chk("t2_timeout_err", {31'd0, timeout_err_o}, 32'd1);
    chk("t2_timeout_done", {31'd0, done_o}, 32'd1);
    chk("t2_timeout_cnt", irq_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
